// File: rtl/key_event_ctrl_if.sv
// rtl/key_event_ctrl_if.sv - key event valid/ready port bundle
//
// Purpose: carries one classified key event from the key front end to the
// command logic.
// Signals:
//   evt_valid  event available (master drives)
//   evt_ready  consumer accepts event (slave drives)
//   evt_key    index of the key that produced the event
//   evt_type   0 = short press, 1 = long press
interface key_event_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_key;
  logic       evt_type;

  modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - four-key debounce, short/long classification, round-robin event port
//
// Purpose: synchronises and debounces four active-low push keys, classifies
// each press as short or long, and delivers the events one at a time through
// a valid/ready port with round-robin fairness between keys.
// Ports:
//   sys_clk       system clock
//   sys_rst_n     asynchronous active-low reset
//   key[3:0]      raw keys, active-low, asynchronous to sys_clk
//   evt           event port (master side of key_event_ctrl_if)
//   key_level     debounced key levels, 1 = held
//   evt_overflow  one-cycle pulse when an event was dropped
module key_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [3:0]               key,
  key_event_ctrl_if.master         evt,
  output logic [3:0]               key_level,
  output logic                     evt_overflow
);

  localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);
  localparam logic [25:0] LONG_MAX  = 26'(LONG_CYCLES);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state;
  logic [3:0]  sync1, sync2;
  logic [23:0] db_cnt   [4];
  logic [25:0] hold_cnt [4];
  logic [3:0]  long_fired;
  logic [3:0]  pend, ptype;
  logic [1:0]  rr;

  logic [3:0]  differ, toggle, rise, fall;
  logic [3:0]  long_ev, short_ev, raise, grant, drop;
  logic [1:0]  sel;
  logic        any_pend;

  // Per-key event detection. A long event on the very cycle the key is
  // released still wins, so a press never yields both a long and a short.
  always_comb begin
    differ   = '0;
    toggle   = '0;
    long_ev  = '0;
    for (int i = 0; i < 4; i++) begin
      differ[i]  = (~sync2[i]) != key_level[i];
      toggle[i]  = differ[i] && (db_cnt[i] == DB_LAST);
      long_ev[i] = key_level[i] && !long_fired[i] && (hold_cnt[i] == LONG_LAST);
    end
    rise     = toggle & ~key_level;
    fall     = toggle & key_level;
    short_ev = fall & ~long_fired & ~long_ev;
    raise    = long_ev | short_ev;
  end

  // Round-robin pick: first pending key after the last one accepted.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found    = 1'b0;
    idx      = '0;
    sel      = '0;
    any_pend = |pend;
    for (int k = 1; k <= 4; k++) begin
      idx = rr + 2'(k);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    grant = (state == IDLE && any_pend) ? (4'b0001 << sel) : 4'b0000;
    // A slot being granted this cycle can take the new event without loss.
    drop  = raise & pend & ~grant;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1        <= 4'b1111;
      sync2        <= 4'b1111;
      key_level    <= '0;
      long_fired   <= '0;
      pend         <= '0;
      ptype        <= '0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync1        <= key;
      sync2        <= sync1;
      evt_overflow <= |drop;
      for (int i = 0; i < 4; i++) begin
        if (toggle[i]) begin
          key_level[i] <= ~key_level[i];
          db_cnt[i]    <= '0;
        end else if (differ[i]) begin
          db_cnt[i] <= db_cnt[i] + 24'd1;
        end else begin
          db_cnt[i] <= '0;
        end

        if (rise[i])
          hold_cnt[i] <= '0;
        else if (key_level[i] && hold_cnt[i] != LONG_MAX)
          hold_cnt[i] <= hold_cnt[i] + 26'd1;

        if (fall[i])
          long_fired[i] <= 1'b0;
        else if (long_ev[i])
          long_fired[i] <= 1'b1;

        if (raise[i]) begin
          if (!drop[i]) begin
            pend[i]  <= 1'b1;
            ptype[i] <= long_ev[i];
          end
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      evt.evt_valid <= 1'b0;
      evt.evt_key   <= '0;
      evt.evt_type  <= 1'b0;
      rr            <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) begin
            evt.evt_key   <= sel;
            evt.evt_type  <= ptype[sel];
            evt.evt_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (evt.evt_ready) begin
            rr            <= evt.evt_key;
            evt.evt_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - directed self-checking bench for key_event_ctrl
module tb_key_event_ctrl;
  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key;
  logic [3:0] key_level;
  logic       evt_overflow;

  key_event_ctrl_if evt_bus ();

  key_event_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key         (key),
    .evt         (evt_bus.master),
    .key_level   (key_level),
    .evt_overflow(evt_overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  logic [2:0] ev_q[$];
  int ovf_cnt   = 0;
  int valid_cyc = 0;
  int lvl_cyc   = 0;
  int lvl2_cyc  = 0;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (evt_bus.evt_valid && evt_bus.evt_ready)
        ev_q.push_back({evt_bus.evt_key, evt_bus.evt_type});
      if (evt_overflow) ovf_cnt++;
      if (evt_bus.evt_valid) valid_cyc++;
      if (key_level != 4'b0000) lvl_cyc++;
      if (key_level[2]) lvl2_cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic logic [3:0] ev_at(input int idx);
    if (idx < ev_q.size()) return {1'b0, ev_q[idx]};
    return 4'b1000;
  endfunction

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    cyc(3);
    sys_rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic tap(input int k, input int len);
    key[k] = 1'b0;
    cyc(len);
    key[k] = 1'b1;
  endtask

  int base, ovf0, vc0, lc0, l2c0;

  initial begin
    key = 4'b1111;
    evt_bus.evt_ready = 1'b1;
    sys_rst_n = 1'b0;
    cyc(3);
    check("rst_valid", evt_bus.evt_valid, 0);
    check("rst_key", evt_bus.evt_key, 0);
    check("rst_type", evt_bus.evt_type, 0);
    check("rst_level", key_level, 0);
    check("rst_ovf", evt_overflow, 0);
    sys_rst_n = 1'b1;

    // idle after reset
    vc0 = valid_cyc; lc0 = lvl_cyc; ovf0 = ovf_cnt;
    cyc(100);
    check("idle_valid_cycles", valid_cyc - vc0, 0);
    check("idle_level_cycles", lvl_cyc - lc0, 0);
    check("idle_ovf", ovf_cnt - ovf0, 0);

    // short press on key0, debounce latency 6 cycles
    base = ev_q.size();
    key[0] = 1'b0;
    cyc(5);
    check("db_lat_before", key_level[0], 0);
    cyc(1);
    check("db_lat_after", key_level[0], 1);
    cyc(4);
    key[0] = 1'b1;
    cyc(20);
    check("short_count", ev_q.size() - base, 1);
    check("short_evt", ev_at(base), 4'b0000);
    check("short_level_rel", key_level[0], 0);

    // bouncing key2 never accepted
    base = ev_q.size(); l2c0 = lvl2_cyc;
    key[2] = 1'b0; cyc(3);
    key[2] = 1'b1; cyc(1);
    key[2] = 1'b0; cyc(3);
    key[2] = 1'b1; cyc(20);
    check("bounce_level", lvl2_cyc - l2c0, 0);
    check("bounce_events", ev_q.size() - base, 0);

    // long press on key1
    base = ev_q.size();
    key[1] = 1'b0;
    cyc(35);
    check("long_while_held_cnt", ev_q.size() - base, 1);
    check("long_evt", ev_at(base), 4'b0011);
    cyc(5);
    key[1] = 1'b1;
    cyc(20);
    check("long_no_short", ev_q.size() - base, 1);

    // simultaneous key0/key3 with stall; fresh reset puts key0 first
    do_reset();
    base = ev_q.size();
    evt_bus.evt_ready = 1'b0;
    key = 4'b0110;
    cyc(8);
    key = 4'b1111;
    cyc(12);
    check("stall_valid", evt_bus.evt_valid, 1);
    check("stall_key", evt_bus.evt_key, 0);
    check("stall_type", evt_bus.evt_type, 0);
    cyc(3);
    check("stall_key_stable", evt_bus.evt_key, 0);
    check("stall_valid_stable", evt_bus.evt_valid, 1);
    evt_bus.evt_ready = 1'b1;
    cyc(1);
    check("rr_gap_valid", evt_bus.evt_valid, 0);
    cyc(1);
    check("rr_second_valid", evt_bus.evt_valid, 1);
    check("rr_second_key", evt_bus.evt_key, 3);
    cyc(3);
    check("rr_count", ev_q.size() - base, 2);
    check("rr_first", ev_at(base), 4'b0000);
    check("rr_second", ev_at(base + 1), 4'b0110);

    // overflow: one in flight, one pending, third dropped
    base = ev_q.size(); ovf0 = ovf_cnt;
    evt_bus.evt_ready = 1'b0;
    tap(0, 8); cyc(10);
    tap(0, 8); cyc(10);
    check("ovf_before_third", ovf_cnt - ovf0, 0);
    tap(0, 8); cyc(10);
    check("ovf_third", ovf_cnt - ovf0, 1);
    evt_bus.evt_ready = 1'b1;
    cyc(10);
    check("ovf_delivered", ev_q.size() - base, 2);

    // reset mid-HOLD clears in-flight and pending events
    evt_bus.evt_ready = 1'b0;
    tap(0, 8); cyc(10);
    tap(0, 8); cyc(10);
    check("pre_rst_valid", evt_bus.evt_valid, 1);
    base = ev_q.size();
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_valid", evt_bus.evt_valid, 0);
    cyc(2);
    sys_rst_n = 1'b1;
    evt_bus.evt_ready = 1'b1;
    cyc(30);
    check("post_rst_events", ev_q.size() - base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
